// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, FSM states,
// datapath select codes and trap causes. CTRL_SYSTEM_EN adds the HALT state.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_EXEC_R    = 5'd2,
    S_EXEC_I    = 5'd3,
    S_LUI       = 5'd4,
    S_AUIPC     = 5'd5,
    S_ALU_WB    = 5'd6,
    S_MEM_ADDR  = 5'd7,
    S_MEM_READ  = 5'd8,
    S_MEM_WB    = 5'd9,
    S_MEM_WRITE = 5'd10,
    S_BRANCH    = 5'd11,
    S_JAL       = 5'd12,
    S_JALR      = 5'd13,
    S_JUMP      = 5'd14,
    S_TRAP      = 5'd15
`ifdef CTRL_SYSTEM_EN
    , S_HALT    = 5'd16
`endif
  } state_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // Branch condition from funct3 and the ALU compare flags; 010/011 never reach here.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt, input logic ltu);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Memory wait-state counter: counts cycles with a request pending and no ready, and
// flags the cycle in which the wait reaches MEM_TIMEOUT (0 disables the flag).
module ctrl_mem_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] SAT  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (busy && !ready && cnt != SAT)
      cnt <= cnt + 1'b1;
  end

  // This wait cycle is the MEM_TIMEOUT-th; a ready in the same cycle still wins.
  assign timeout = (MEM_TIMEOUT > 0) && busy && !ready && (cnt == LAST);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core with memory handshake, bus timeout and
// sticky trap. Define CTRL_SYSTEM_EN to make ECALL/EBREAK halt instead of trapping.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] alu_op,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       halted,
  output logic [4:0] state_o
);

  state_t     state, state_next;
  logic [1:0] cause_next;
  logic       timeout;
  logic       state_change;
  logic       illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
    end
  end

  // Reset removes the request immediately, even in the middle of an access.
  assign mem_req = rst && (state == S_FETCH || state == S_MEM_READ || state == S_MEM_WRITE);

  assign state_change = (state_next != state);

  ctrl_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .busy   (mem_req),
    .ready  (mem_ready),
    .clear  (state_change),
    .timeout(timeout)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cause_next = trap_cause;
    illegal    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALU_ADD;

    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS;
        end
      end

      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = (opcode == OP_JAL || opcode == OP_JALR) ? SRCB_FOUR : SRCB_IMM;
        case (opcode)
          OP_R:
            if (funct7 == 7'b0000000 || funct7 == 7'b0100000) state_next = S_EXEC_R;
            else illegal = 1'b1;
          OP_IMM:             state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:
            if (funct3[2:1] != 2'b01) state_next = S_BRANCH;
            else illegal = 1'b1;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:
            if (funct3 == 3'b000) state_next = S_JALR;
            else illegal = 1'b1;
          OP_LUI:             state_next = S_LUI;
          OP_AUIPC:           state_next = S_AUIPC;
`ifdef CTRL_SYSTEM_EN
          OP_SYSTEM:
            if (funct3 == 3'b000) state_next = S_HALT;
            else illegal = 1'b1;
`else
          OP_SYSTEM:          illegal = 1'b1;
`endif
          default:            illegal = 1'b1;
        endcase
        if (illegal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end

      S_EXEC_R: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        state_next = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        state_next = S_ALU_WB;
      end

      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALU_WB;
      end

      S_AUIPC: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ, S_MEM_WRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = (state == S_MEM_WRITE);
        if (mem_ready) begin
          state_next = (state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS;
        end
      end

      S_MEM_WB: begin
        ResultSrc  = RES_MEM;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALU_SUB;
        PCWrite    = branch_taken(funct3, zero, lt, ltu);
        state_next = S_FETCH;
      end

      // Link value oldPC+4 sits in ALUOut from DECODE while the ALU forms the target.
      S_JAL, S_JALR: begin
        RegWrite   = 1'b1;
        ALUSrcA    = (state == S_JAL) ? SRCA_OLDPC : SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_JUMP;
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: state_next = S_TRAP;

`ifdef CTRL_SYSTEM_EN
      S_HALT: state_next = S_HALT;
`endif

      default: state_next = S_FETCH;
    endcase

    if (!rst) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

  assign trap    = (state == S_TRAP);
  assign state_o = state;

`ifdef CTRL_SYSTEM_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl (MEM_TIMEOUT=4): instruction sequences,
// wait states, bus timeout, illegal encodings and SYSTEM handling under CTRL_SYSTEM_EN.
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, alu_op, trap_cause;
  logic       trap, halted;
  logic [4:0] state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause), .halted(halted),
    .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Assert reset between edges, check the asynchronous effect, release after an edge.
  task automatic reset_async(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_state"}, state_o, S_FETCH);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_trap"}, trap, 1'b0);
    check({tag, "_cause"}, trap_cause, 2'b00);
    check({tag, "_halted"}, halted, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic l, input logic lu, input logic exp_pc);
    set_ir(7'b1100011, f3, 7'b0000000);
    zero = z; lt = l; ltu = lu; mem_ready = 1'b1;
    #1 check({tag, "_fetch"}, state_o, S_FETCH);
    tick();
    check({tag, "_dec_srcb"}, ALUSrcB, 2'b01);
    tick();
    check({tag, "_state"}, state_o, S_BRANCH);
    check({tag, "_alu_op"}, alu_op, 2'b01);
    check({tag, "_pcwrite"}, PCWrite, exp_pc);
    tick();
    check({tag, "_back"}, state_o, S_FETCH);
  endtask

  initial begin
    // Reset with mem_ready already high: no fetch strobes, FETCH selects visible.
    #2;
    check("rst_state", state_o, S_FETCH);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_irwrite", IRWrite, 1'b0);
    check("rst_pcwrite", PCWrite, 1'b0);
    check("rst_trap", trap, 1'b0);
    check("rst_cause", trap_cause, 2'b00);
    check("rst_srcb", ALUSrcB, 2'b10);
    check("rst_result", ResultSrc, 2'b10);
    check("rst_halted", halted, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // ADD x2,x1,x2 (0x00208133), zero-wait: 4 cycles.
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    #1;
    check("add_fetch_req", mem_req, 1'b1);
    check("add_fetch_ir", IRWrite, 1'b1);
    check("add_fetch_pc", PCWrite, 1'b1);
    check("add_fetch_adr", AdrSrc, 1'b0);
    tick();
    check("add_decode", state_o, S_DECODE);
    check("add_dec_srca", ALUSrcA, 2'b01);
    check("add_dec_pc", PCWrite, 1'b0);
    tick();
    check("add_exec", state_o, S_EXEC_R);
    check("add_exec_srca", ALUSrcA, 2'b10);
    check("add_exec_srcb", ALUSrcB, 2'b00);
    check("add_exec_aluop", alu_op, 2'b10);
    check("add_exec_regw", RegWrite, 1'b0);
    tick();
    check("add_wb", state_o, S_ALU_WB);
    check("add_wb_regw", RegWrite, 1'b1);
    check("add_wb_result", ResultSrc, 2'b00);
    tick();
    check("add_done", state_o, S_FETCH);
    check("add_done_regw", RegWrite, 1'b0);

    // LW with three wait cycles in MEM_READ: 8 cycles total, no timeout at 3 waits.
    set_ir(7'b0000011, 3'b010, 7'b0000000);
    #1 check("lw_fetch", state_o, S_FETCH);
    tick();
    check("lw_decode", state_o, S_DECODE);
    tick();
    check("lw_addr", state_o, S_MEM_ADDR);
    check("lw_addr_srca", ALUSrcA, 2'b10);
    check("lw_addr_srcb", ALUSrcB, 2'b01);
    check("lw_addr_req", mem_req, 1'b0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_state", state_o, S_MEM_READ);
      check("lw_wait_req", mem_req, 1'b1);
      check("lw_wait_adr", AdrSrc, 1'b1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_rd_state", state_o, S_MEM_READ);
    check("lw_rd_req", mem_req, 1'b1);
    check("lw_rd_adr", AdrSrc, 1'b1);
    check("lw_rd_memw", MemWrite, 1'b0);
    tick();
    check("lw_wb", state_o, S_MEM_WB);
    check("lw_wb_result", ResultSrc, 2'b01);
    check("lw_wb_regw", RegWrite, 1'b1);
    tick();
    check("lw_done", state_o, S_FETCH);

    // SW zero-wait: 4 cycles.
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    tick();
    tick();
    check("sw_addr", state_o, S_MEM_ADDR);
    tick();
    check("sw_state", state_o, S_MEM_WRITE);
    check("sw_memw", MemWrite, 1'b1);
    check("sw_req", mem_req, 1'b1);
    check("sw_adr", AdrSrc, 1'b1);
    tick();
    check("sw_done", state_o, S_FETCH);
    check("sw_done_memw", MemWrite, 1'b0);

    // Branch set against fixed flags.
    run_branch("bltu", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
    run_branch("bgeu", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
    run_branch("bne",  3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
    run_branch("bge",  3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    run_branch("beq",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1);

    // JALR x1,0(x1): link in JALR, PC update in JUMP.
    set_ir(7'b1100111, 3'b000, 7'b0000000);
    tick();
    check("jalr_dec_srcb", ALUSrcB, 2'b10);
    tick();
    check("jalr_state", state_o, S_JALR);
    check("jalr_regw", RegWrite, 1'b1);
    check("jalr_srca", ALUSrcA, 2'b10);
    check("jalr_srcb", ALUSrcB, 2'b01);
    check("jalr_pcw", PCWrite, 1'b0);
    tick();
    check("jalr_jump", state_o, S_JUMP);
    check("jalr_jump_pcw", PCWrite, 1'b1);
    check("jalr_jump_regw", RegWrite, 1'b0);
    tick();
    check("jalr_done", state_o, S_FETCH);

    // JAL uses oldPC as the target base.
    set_ir(7'b1101111, 3'b000, 7'b0000000);
    tick();
    tick();
    check("jal_state", state_o, S_JAL);
    check("jal_srca", ALUSrcA, 2'b01);
    tick();
    tick();
    check("jal_done", state_o, S_FETCH);

    // LUI: zero + imm, then writeback.
    set_ir(7'b0110111, 3'b000, 7'b0000000);
    tick();
    tick();
    check("lui_state", state_o, S_LUI);
    check("lui_srca", ALUSrcA, 2'b11);
    check("lui_srcb", ALUSrcB, 2'b01);
    tick();
    check("lui_wb", state_o, S_ALU_WB);
    tick();

    // R-type with funct7=0000001 is illegal; trap is sticky.
    set_ir(7'b0110011, 3'b000, 7'b0000001);
    tick();
    tick();
    check("ill_r_state", state_o, S_TRAP);
    check("ill_r_trap", trap, 1'b1);
    check("ill_r_cause", trap_cause, 2'b01);
    check("ill_r_req", mem_req, 1'b0);
    tick();
    check("ill_r_sticky", state_o, S_TRAP);
    reset_async("ill_r_rst");

    // Branch funct3=010 is illegal.
    set_ir(7'b1100011, 3'b010, 7'b0000000);
    tick();
    tick();
    check("ill_br_cause", trap_cause, 2'b01);
    reset_async("ill_br_rst");

    // mem_ready stuck low in FETCH: TRAP after 4 cycles with bus cause.
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    mem_ready = 1'b0;
    #1 check("to_fetch_ir", IRWrite, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait", state_o, S_FETCH);
    end
    tick();
    check("to_state", state_o, S_TRAP);
    check("to_cause", trap_cause, 2'b10);
    check("to_req", mem_req, 1'b0);
    reset_async("to_rst");

    // Reset mid-wait drops mem_req at once and restarts the wait count.
    tick();
    check("mid_req_before", mem_req, 1'b1);
    reset_async("mid_rst");

    // mem_ready rising in the 4th waiting cycle completes the fetch instead.
    for (int i = 0; i < 3; i++) begin
      check("late_wait", state_o, S_FETCH);
      tick();
    end
    mem_ready = 1'b1;
    #1 check("late_ir", IRWrite, 1'b1);
    tick();
    check("late_decode", state_o, S_DECODE);
    check("late_trap", trap, 1'b0);
    tick();
    tick();
    tick();
    check("late_done", state_o, S_FETCH);

    // SYSTEM funct3=000 (ECALL).
    set_ir(7'b1110011, 3'b000, 7'b0000000);
    tick();
    tick();
`ifdef CTRL_SYSTEM_EN
    check("sys_state", state_o, S_HALT);
    check("sys_halted", halted, 1'b1);
    check("sys_trap", trap, 1'b0);
    tick();
    check("sys_sticky", halted, 1'b1);
`else
    check("sys_state", state_o, S_TRAP);
    check("sys_cause", trap_cause, 2'b01);
    check("sys_halted", halted, 1'b0);
    tick();
    check("sys_sticky", trap, 1'b1);
`endif
    reset_async("sys_rst");

    // CSR-style SYSTEM encoding traps in both builds.
    set_ir(7'b1110011, 3'b001, 7'b0000000);
    tick();
    tick();
    check("csr_state", state_o, S_TRAP);
    check("csr_cause", trap_cause, 2'b01);
    reset_async("csr_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
